// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : i2c_pkg
//  Description: Shared I2C write-queue definitions: sequencer state
//               encodings and the packed {address, data} queue entry.
//  Revision   : 1.0  initial release
// ============================================================================
package i2c_pkg;

    // Queue entry width: 7-bit slave address + 8-bit data byte
    localparam int unsigned c_entry_w = 15;

    // Sequencer states
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_launch  = 3'd1;
    localparam logic [2:0] c_st_wait_hi = 3'd2;
    localparam logic [2:0] c_st_wait_lo = 3'd3;
    localparam logic [2:0] c_st_gap     = 3'd4;

    // Entry packing: addr occupies [14:8], data occupies [7:0]
    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } i2c_entry_t;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : i2c_cmd_fifo
//  Description: Parameterised synchronous FIFO for I2C write commands.
//               Circular buffer with wrapping pointers and a separate level
//               counter; reports full/empty/level and a per-push overflow.
//  Revision   : 1.0  initial release
// ============================================================================
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = c_entry_w
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_entry,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int unsigned              c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]         c_lvl_max = DEPTH[c_ptr_w:0];
    localparam logic [c_ptr_w:0]         c_lvl_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0]       c_ptr_one = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;
    logic               r_overflow;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Full is judged before any pop in the same cycle, so a push into a
    // full-and-popping FIFO is still dropped.
    assign o_full    = (r_level == c_lvl_max);
    assign o_empty   = (r_level == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    assign o_head     = r_mem[r_rd_ptr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

    // Entry storage: written on every accepted push
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers, level and overflow pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_push && o_full;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : i2c_cmd_fifo
`default_nettype wire

// File: rtl/i2c_wr_queue.sv
`default_nettype none
// ============================================================================
//  Module     : i2c_wr_queue
//  Description: Command queue and sequencer in front of the I2C single-byte
//               write master. Pops queued {addr, data} entries, launches each
//               as one write, waits for completion, enforces an idle gap and
//               counts completed and failed transactions.
//  Revision   : 1.0  initial release
// ============================================================================
module i2c_wr_queue
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [6:0]               i_push_addr,
    input  logic [7:0]               i_push_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_wr_start,
    output logic [6:0]               o_slave_addr,
    output logic [7:0]               o_wr_byte,
    input  logic                     i_busy,
    input  logic                     i_error,
    output logic                     o_active,
    output logic [7:0]               o_done_cnt,
    output logic [7:0]               o_err_cnt
);

    // Shared cycle counter covers both the start timeout and the gap
    localparam int unsigned          c_cnt_w    = 16;
    localparam logic [c_cnt_w-1:0]   c_gap_last = (GAP_CYCLES == 0) ? '0 : c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_to_last  = c_cnt_w'(START_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err_flag;
    logic               r_wr_start;
    logic [6:0]         r_slave_addr;
    logic [7:0]         r_wr_byte;
    logic [7:0]         r_done_cnt;
    logic [7:0]         r_err_cnt;

    logic               w_empty;
    logic               w_pop;
    logic               w_start;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_err_seen;
    logic               w_done_inc;
    logic               w_err_inc;
    i2c_entry_t         w_push_entry;
    i2c_entry_t         w_head;

    assign w_push_entry.addr = i_push_addr;
    assign w_push_entry.data = i_push_data;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (i_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (o_full),
        .o_empty      (w_empty),
        .o_level      (o_level),
        .o_overflow   (o_overflow)
    );

    assign o_empty = w_empty;

    // Error seen in this cycle or earlier in the current WAIT_LO
    assign w_err_seen = r_err_flag || i_error;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_empty && !i_busy) begin
                    w_next = c_st_launch;
                end
            end
            c_st_launch: begin
                w_next = c_st_wait_hi;
            end
            c_st_wait_hi: begin
                if (i_busy) begin
                    w_next = c_st_wait_lo;
                end else if (r_cnt == c_to_last) begin
                    w_next = c_st_gap;
                end
            end
            c_st_wait_lo: begin
                if (!i_busy) begin
                    w_next = c_st_gap;
                end
            end
            c_st_gap: begin
                // Counter is cleared on entry, so GAP_CYCLES=0 exits after one cycle
                if (r_cnt == c_gap_last) begin
                    w_next = c_st_idle;
                end
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    // Per-state control strobes
    always_comb begin
        w_pop      = 1'b0;
        w_start    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_done_inc = 1'b0;
        w_err_inc  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_pop = (w_next == c_st_launch);
            end
            c_st_launch: begin
                w_start   = 1'b1;
                w_cnt_clr = 1'b1;
            end
            c_st_wait_hi: begin
                w_cnt_inc = 1'b1;
                if (w_next == c_st_gap) begin
                    w_cnt_clr = 1'b1;
                    w_err_inc = 1'b1;
                end
            end
            c_st_wait_lo: begin
                if (w_next == c_st_gap) begin
                    w_cnt_clr  = 1'b1;
                    w_done_inc = !w_err_seen;
                    w_err_inc  = w_err_seen;
                end
            end
            c_st_gap: begin
                w_cnt_inc = 1'b1;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // Timeout / gap cycle counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Sticky error flag, live only while waiting for busy to fall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_flag <= 1'b0;
        end else if (r_state == c_st_wait_lo && i_busy) begin
            r_err_flag <= w_err_seen;
        end else begin
            r_err_flag <= 1'b0;
        end
    end

    // Launch pulse and command hold registers toward the master
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_start   <= 1'b0;
            r_slave_addr <= '0;
            r_wr_byte    <= '0;
        end else begin
            r_wr_start <= w_start;
            if (w_pop) begin
                r_slave_addr <= w_head.addr;
                r_wr_byte    <= w_head.data;
            end
        end
    end

    // Completion counter wraps, error counter saturates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_done_inc) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
            if (w_err_inc && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign o_active     = (r_state != c_st_idle);
    assign o_wr_start   = r_wr_start;
    assign o_slave_addr = r_slave_addr;
    assign o_wr_byte    = r_wr_byte;
    assign o_done_cnt   = r_done_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule : i2c_wr_queue
`default_nettype wire

// File: tb/tb_i2c_wr_queue.sv
`default_nettype none
// ============================================================================
//  Module     : tb_i2c_wr_queue
//  Description: Scoreboard bench for i2c_wr_queue with a behavioural I2C
//               master model, directed scenarios and randomized traffic.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_i2c_wr_queue;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;
    localparam int TO    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_push = 1'b0;
    logic [6:0]    i_push_addr = '0;
    logic [7:0]    i_push_data = '0;
    logic          i_busy = 1'b0;
    logic          i_error = 1'b0;
    logic          o_full, o_empty, o_overflow, o_wr_start, o_active;
    logic [LW-1:0] o_level;
    logic [6:0]    o_slave_addr;
    logic [7:0]    o_wr_byte;
    logic [7:0]    o_done_cnt, o_err_cnt;

    i2c_wr_queue #(
        .DEPTH         (DEPTH),
        .GAP_CYCLES    (GAP),
        .START_TIMEOUT (TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (i_push),
        .i_push_addr  (i_push_addr),
        .i_push_data  (i_push_data),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_level      (o_level),
        .o_overflow   (o_overflow),
        .o_wr_start   (o_wr_start),
        .o_slave_addr (o_slave_addr),
        .o_wr_byte    (o_wr_byte),
        .i_busy       (i_busy),
        .i_error      (i_error),
        .o_active     (o_active),
        .o_done_cnt   (o_done_cnt),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Scoreboard and reference state
    logic [14:0] exp_q[$];
    int errors = 0, checks = 0;
    int exp_done = 0, exp_err = 0;
    int lvl_model = 0, starts_seen = 0;
    int fall_cyc = 0, push_edge = 0;
    bit pend_at_fall = 0, start_pending = 0, ovf_ok = 0;

    // Master model controls
    bit m_force = 0, m_rand = 0, m_nobusy_next = 0, m_err_next = 0, m_cur_err = 0;
    int m_len = 40, m_err_at_next = 5, m_left = 0, m_err_at = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every launch and checks launch timing
    logic [14:0] mon_e;
    logic [6:0]  prev_addr = '0;
    logic [7:0]  prev_byte = '0;
    bit          prev_start = 0;
    initial begin : monitor
        forever begin
            @(negedge i_clk);
            if (o_wr_start) begin
                starts_seen++;
                lvl_model--;
                start_pending = 1;
                if (prev_start) check("start_pulse_width", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("start_addr", o_slave_addr, mon_e[14:8]);
                    check("start_byte", o_wr_byte, mon_e[7:0]);
                    check("addr_before_start", prev_addr, o_slave_addr);
                    check("byte_before_start", prev_byte, o_wr_byte);
                end
                if (pend_at_fall) check("gap_after_busy_fall", cyc - fall_cyc, GAP + 3);
                pend_at_fall = 0;
            end
            if (o_overflow && !ovf_ok) check("spurious_overflow", 1, 0);
            prev_addr  = o_slave_addr;
            prev_byte  = o_wr_byte;
            prev_start = o_wr_start;
        end
    end

    // Master model: busy one cycle after a sampled start, optional error
    // pulse while busy, or never busy (launch failure)
    initial begin : master
        int  len, at;
        bit  nob, err;
        forever begin
            @(posedge i_clk); #1;
            i_error = 1'b0;
            if (!i_rst_n) begin
                i_busy = 1'b0; m_left = 0; start_pending = 0;
            end else if (m_force) begin
                i_busy = 1'b1;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    i_busy = 1'b0;
                    fall_cyc = cyc;
                    pend_at_fall = (exp_q.size() > 0);
                    if (m_cur_err) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                    else           exp_done = (exp_done + 1) % 256;
                end else if (m_cur_err && m_left == m_err_at) begin
                    i_error = 1'b1;
                end
            end else begin
                i_busy = 1'b0;
                if (start_pending) begin
                    start_pending = 0;
                    if (m_rand) begin
                        nob = ($urandom_range(0, 7) == 0);
                        err = ($urandom_range(0, 4) == 0);
                        len = $urandom_range(2, 30);
                        at  = $urandom_range(1, len - 1);
                    end else begin
                        nob = m_nobusy_next; err = m_err_next;
                        len = m_len;         at  = m_err_at_next;
                        m_nobusy_next = 0;   m_err_next = 0;
                    end
                    if (nob) begin
                        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                    end else begin
                        i_busy = 1'b1; m_left = len; m_cur_err = err; m_err_at = at;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Push one entry; accepted entries become expected launches
    task automatic push(input logic [6:0] a, input logic [7:0] d, input bit accept);
        i_push = 1'b1; i_push_addr = a; i_push_data = d;
        @(posedge i_clk); #1;
        i_push = 1'b0;
        push_edge = cyc;
        if (accept) begin
            exp_q.push_back({a, d});
            lvl_model++;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        @(negedge i_clk);
        while (!(exp_q.size() == 0 && !o_active && !i_busy && !start_pending) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL %s: not idle after %0d cycles, required idle", name, n);
        end
        tick(1);
    endtask

    task automatic wait_start(input int budget, input string name, output int s);
        int n = 0;
        s = -1;
        do begin @(negedge i_clk); n++; end while (!o_wr_start && n < budget);
        if (!o_wr_start) begin
            checks++; errors++;
            $display("FAIL %s: no start within %0d cycles, required a start", name, budget);
        end else begin
            s = cyc;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s, e0, d0, snap;
        // ---- reset state ----
        #12;
        check("rst_empty", o_empty, 1);      check("rst_full", o_full, 0);
        check("rst_level", o_level, 0);      check("rst_active", o_active, 0);
        check("rst_start", o_wr_start, 0);   check("rst_done", o_done_cnt, 0);
        check("rst_err", o_err_cnt, 0);      check("rst_addr", o_slave_addr, 0);
        tick(2);
        i_rst_n = 1'b1;
        tick(2);

        // ---- single entry ----
        push(7'h56, 8'hA5, 1);
        wait_start(10, "single_start", s);
        check("single_latency", s - push_edge, 2);
        wait_idle(200, "single_idle");
        check("single_done", o_done_cnt, 1);
        check("single_err", o_err_cnt, 0);
        check("single_empty", o_empty, 1);

        // ---- fill and overflow, master held busy ----
        m_force = 1; tick(1);
        ovf_ok = 1;
        for (int k = 1; k <= 5; k++) begin
            push(7'(k + 8'h10), 8'(k * 17), k <= DEPTH);
            @(negedge i_clk);
            check("fill_full", o_full, (k >= DEPTH) ? 1 : 0);
            check("fill_overflow", o_overflow, (k == DEPTH + 1) ? 1 : 0);
            check("fill_level", o_level, (k >= DEPTH) ? DEPTH : k);
        end
        @(negedge i_clk);
        check("overflow_one_cycle", o_overflow, 0);
        ovf_ok = 0;
        d0 = o_done_cnt;
        m_force = 0;
        wait_idle(800, "drain_idle");
        check("drain_done", o_done_cnt, (d0 + DEPTH) % 256);

        // ---- back-to-back three entries ----
        d0 = o_done_cnt; snap = starts_seen;
        push(7'h21, 8'h01, 1); push(7'h22, 8'h02, 1); push(7'h23, 8'h03, 1);
        wait_idle(800, "b2b_idle");
        check("b2b_starts", starts_seen - snap, 3);
        check("b2b_done", o_done_cnt, (d0 + 3) % 256);

        // ---- error path ----
        d0 = o_done_cnt; e0 = o_err_cnt;
        m_err_next = 1; m_err_at_next = 20;
        push(7'h33, 8'hC3, 1); push(7'h34, 8'hC4, 1);
        wait_idle(800, "err_idle");
        check("err_path_err", o_err_cnt, e0 + 1);
        check("err_path_done", o_done_cnt, (d0 + 1) % 256);

        // ---- start timeout ----
        e0 = o_err_cnt;
        m_nobusy_next = 1;
        push(7'h44, 8'h5A, 1);
        wait_start(10, "to_start", s);
        check("to_popped", o_level, 0);
        repeat (TO - 1) @(negedge i_clk);
        check("to_err_before", o_err_cnt, e0);
        check("to_active", o_active, 1);
        @(negedge i_clk);
        check("to_err_after", o_err_cnt, e0 + 1);
        wait_idle(200, "to_idle");

        // ---- randomized traffic ----
        m_rand = 1;
        for (int t = 0; t < 40; t++) begin
            tick($urandom_range(1, 40));
            if (lvl_model < DEPTH)
                push(7'($urandom), 8'($urandom), 1);
        end
        wait_idle(5000, "rand_idle");
        m_rand = 0;
        check("rand_done", o_done_cnt, exp_done);
        check("rand_err", o_err_cnt, exp_err);
        check("rand_empty", o_empty, 1);

        // ---- reset mid-WAIT_LO with two entries queued ----
        m_len = 100;
        push(7'h61, 8'h11, 1); push(7'h62, 8'h12, 1); push(7'h63, 8'h13, 1);
        wait_start(10, "rst_mid_start", s);
        tick(6);
        check("pre_rst_level", o_level, 2);
        check("pre_rst_busy_active", o_active, 1);
        #2 i_rst_n = 1'b0;
        #1;
        exp_q.delete(); lvl_model = 0; exp_done = 0; exp_err = 0; pend_at_fall = 0;
        check("mid_rst_done", o_done_cnt, 0);   check("mid_rst_err", o_err_cnt, 0);
        check("mid_rst_level", o_level, 0);     check("mid_rst_start", o_wr_start, 0);
        check("mid_rst_empty", o_empty, 1);     check("mid_rst_active", o_active, 0);
        check("mid_rst_addr", o_slave_addr, 0); check("mid_rst_byte", o_wr_byte, 0);
        tick(3);
        i_rst_n = 1'b1;
        snap = starts_seen;
        tick(60);
        check("post_rst_active", o_active, 0);
        check("post_rst_no_launch", starts_seen - snap, 0);
        check("post_rst_done", o_done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_i2c_wr_queue
`default_nettype wire
